// File: rtl/regfile_read_sequencer.sv
// regfile_read_sequencer: read-side controller for a 32-entry register file
// whose registers share one tri-state read bus. A two-operand request is
// served by enabling one register per cycle on the bus, capturing each value,
// and returning both operands through a valid/ready response.
// Optional build macro: READ_DEDUP_EN (equal operand addresses are read once).
module regfile_read_sequencer #(
   parameter int NUM_REGS = 32,
   parameter int ADDR_W   = 5,
   parameter int DATA_W   = 32
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic [ADDR_W-1:0]   req_addr_a,
   input  logic [ADDR_W-1:0]   req_addr_b,
   output logic [NUM_REGS-1:0] rd_enable,
   input  logic [DATA_W-1:0]   rd_bus,
   output logic                rsp_valid,
   input  logic                rsp_ready,
   output logic [DATA_W-1:0]   rsp_data_a,
   output logic [DATA_W-1:0]   rsp_data_b
);

   typedef enum logic [1:0] {IDLE, DRIVE_A, DRIVE_B, RESP} state_t;

   localparam logic [NUM_REGS-1:0] ONE = {{(NUM_REGS-1){1'b0}}, 1'b1};

   state_t              state, state_nxt;
   logic [ADDR_W-1:0]   addr_a_q, addr_b_q;
   logic [NUM_REGS-1:0] rd_enable_nxt;
   logic [DATA_W-1:0]   capture;
   logic                same_addr;

   // Register 0 and out-of-range indices decode to no enable: the shift
   // runs off the top for addr >= NUM_REGS and bit 0 is masked off.
   function automatic logic [NUM_REGS-1:0] onehot(input logic [ADDR_W-1:0] addr);
      onehot = (ONE << addr) & ~ONE;
   endfunction

`ifdef READ_DEDUP_EN
   assign same_addr = (addr_a_q == addr_b_q);
`else
   assign same_addr = 1'b0;
`endif

   // Bus value is taken only for an addressable register, otherwise zero.
   assign capture = (|onehot((state == DRIVE_A) ? addr_a_q : addr_b_q)) ? rd_bus : '0;

   assign req_ready = (state == IDLE) && !reset;
   assign rsp_valid = (state == RESP);

   // State register.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // Next state and the next-cycle read enable; enables are computed one
   // cycle ahead so rd_enable itself comes straight from flops.
   always_comb begin
      state_nxt     = state;
      rd_enable_nxt = '0;
      case (state)
         IDLE: begin
            if (req_valid) begin
               state_nxt     = DRIVE_A;
               rd_enable_nxt = onehot(req_addr_a);
            end
         end
         DRIVE_A: begin
            if (same_addr) begin
               state_nxt = RESP;
            end else begin
               state_nxt     = DRIVE_B;
               rd_enable_nxt = onehot(addr_b_q);
            end
         end
         DRIVE_B: state_nxt = RESP;
         RESP:    if (rsp_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Datapath: read enables, latched addresses and captured operands.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         rd_enable  <= '0;
         addr_a_q   <= '0;
         addr_b_q   <= '0;
         rsp_data_a <= '0;
         rsp_data_b <= '0;
      end else begin
         rd_enable <= rd_enable_nxt;
         case (state)
            IDLE: begin
               if (req_valid) begin
                  addr_a_q <= req_addr_a;
                  addr_b_q <= req_addr_b;
               end
            end
            DRIVE_A: begin
               rsp_data_a <= capture;
               if (same_addr) rsp_data_b <= capture;
            end
            DRIVE_B: rsp_data_b <= capture;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_regfile_read_sequencer.sv
// Scoreboard bench for regfile_read_sequencer: directed requests push their
// hand-computed expectations; a negedge monitor pops and checks enables,
// latency and response data. Honours READ_DEDUP_EN like the design.
module tb_regfile_read_sequencer;

`ifdef READ_DEDUP_EN
   localparam bit DEDUP = 1'b1;
`else
   localparam bit DEDUP = 1'b0;
`endif

   typedef struct {
      logic [31:0] en_a;
      logic [31:0] en_b;
      logic [31:0] da;
      logic [31:0] db;
      int          lat;
      bit          gap;
   } exp_t;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [4:0]  req_addr_a = '0;
   logic [4:0]  req_addr_b = '0;
   logic [31:0] rd_enable;
   logic [31:0] rd_bus;
   logic        rsp_valid;
   logic        rsp_ready = 1'b1;
   logic [31:0] rsp_data_a;
   logic [31:0] rsp_data_b;

   logic [31:0] regs [32];
   logic [31:0] bus_idle = 32'h0BAD_0BAD;

   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   exp_t exp_q[$];
   exp_t cur;
   bit   active = 1'b0;
   bit   seen = 1'b0;
   int   acc = 0;
   int   prev_acc = -100;

   regfile_read_sequencer #(.NUM_REGS(32), .ADDR_W(5), .DATA_W(32)) dut (
      .clock(clock), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_addr_a(req_addr_a), .req_addr_b(req_addr_b),
      .rd_enable(rd_enable), .rd_bus(rd_bus),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_data_a(rsp_data_a), .rsp_data_b(rsp_data_b)
   );

   always #5 clock = ~clock;
   always @(posedge clock) cyc++;

   // Tri-state register file model: the enabled register drives the bus,
   // otherwise the bus floats to whatever junk value bus_idle holds.
   always @* begin
      rd_bus = bus_idle;
      for (int i = 0; i < 32; i++)
         if (rd_enable[i]) rd_bus = regs[i];
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: checks every cycle away from the clock edge.
   always @(negedge clock) begin
      if (reset) begin
         active = 1'b0;
         exp_q.delete();
      end else begin
         chk("onehot", 32'($countones(rd_enable) <= 1), 32'd1);
         if (active) begin
            if (!rsp_valid) begin
               if (cyc - acc == 0) chk("rd_enable_a", rd_enable, cur.en_a);
               else if (cyc - acc == 1) chk("rd_enable_b", rd_enable, cur.en_b);
               if (cyc - acc >= cur.lat) begin
                  chk("rsp_latency_late", 32'(cyc - acc), 32'(cur.lat + 1));
                  active = 1'b0;
               end
            end else begin
               if (!seen) chk("rsp_latency", 32'(cyc - acc), 32'(cur.lat));
               seen = 1'b1;
               chk("rsp_data_a", rsp_data_a, cur.da);
               chk("rsp_data_b", rsp_data_b, cur.db);
               chk("req_ready_in_resp", 32'(req_ready), 32'd0);
               chk("rd_enable_in_resp", rd_enable, 32'd0);
               if (rsp_ready) active = 1'b0;
            end
         end else begin
            chk("spurious_rsp_valid", 32'(rsp_valid), 32'd0);
            chk("rd_enable_idle", rd_enable, 32'd0);
         end
         if (req_valid && req_ready) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_accept", 32'd1, 32'd0);
            end else begin
               cur    = exp_q.pop_front();
               active = 1'b1;
               seen   = 1'b0;
               acc    = cyc + 1;
               if (cur.gap) chk("accept_spacing", 32'(acc - prev_acc), 32'd4);
               prev_acc = acc;
            end
         end
      end
   end

   task automatic send(input logic [4:0] a, input logic [4:0] b,
                       input logic [31:0] ea, input logic [31:0] eb,
                       input logic [31:0] da, input logic [31:0] db,
                       input int lat, input bit gap);
      exp_t e;
      bit   ok = 1'b0;
      e.en_a = ea; e.en_b = eb; e.da = da; e.db = db; e.lat = lat; e.gap = gap;
      exp_q.push_back(e);
      req_addr_a = a;
      req_addr_b = b;
      req_valid  = 1'b1;
      for (int i = 0; i < 20 && !ok; i++) begin
         @(negedge clock);
         #1;
         if (req_ready) ok = 1'b1;
      end
      if (!ok) chk("accept_timeout", 32'd0, 32'd1);
      @(posedge clock);
      #2;
   endtask

   task automatic wait_done();
      bit ok = 1'b0;
      for (int i = 0; i < 40 && !ok; i++) begin
         @(posedge clock);
         #2;
         if (!active && exp_q.size() == 0) ok = 1'b1;
      end
      if (!ok) chk("response_timeout", 32'd0, 32'd1);
   endtask

   initial begin
      for (int i = 0; i < 32; i++) regs[i] = 32'h5A00_0000 | 32'(i);
      regs[1]  = 32'h1111_1111;
      regs[2]  = 32'h2222_2222;
      regs[3]  = 32'h0000_00AA;
      regs[7]  = 32'hDEAD_BEEF;
      regs[12] = 32'h1234_5678;
      regs[31] = 32'hCAFE_F00D;

      // Reset state.
      repeat (2) @(posedge clock);
      #2;
      chk("reset_rd_enable", rd_enable, 32'd0);
      chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("reset_data_a", rsp_data_a, 32'd0);
      chk("reset_data_b", rsp_data_b, 32'd0);
      reset = 1'b0;
      #1;
      chk("req_ready_after_reset", 32'(req_ready), 32'd1);

      // Basic two-operand read.
      send(5'd3, 5'd7, 32'h0000_0008, 32'h0000_0080, 32'h0000_00AA, 32'hDEAD_BEEF, 2, 1'b0);
      req_valid = 1'b0;
      wait_done();

      // Register 0 never enables and reads as zero even with the bus high.
      bus_idle = 32'hFFFF_FFFF;
      send(5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 32'd0, DEDUP ? 1 : 2, 1'b0);
      req_valid = 1'b0;
      wait_done();

      // Back-pressure: response held for five cycles while the bus toggles.
      rsp_ready = 1'b0;
      send(5'd31, 5'd1, 32'h8000_0000, 32'h0000_0002, 32'hCAFE_F00D, 32'h1111_1111, 2, 1'b0);
      req_valid = 1'b0;
      for (int i = 0; i < 10 && !rsp_valid; i++) begin
         @(posedge clock);
         #2;
      end
      chk("rsp_valid_before_hold", 32'(rsp_valid), 32'd1);
      for (int i = 0; i < 5; i++) begin
         bus_idle = ~bus_idle;
         @(posedge clock);
         #2;
      end
      rsp_ready = 1'b1;
      @(posedge clock);
      #2;
      rsp_ready = 1'b0;
      #1;
      chk("idle_after_pulse", 32'(req_ready), 32'd1);
      rsp_ready = 1'b1;
      wait_done();

      // Reset asserted mid DRIVE_B drops the request without a response.
      send(5'd3, 5'd7, 32'h0000_0008, 32'h0000_0080, 32'h0000_00AA, 32'hDEAD_BEEF, 2, 1'b0);
      req_valid = 1'b0;
      @(posedge clock);
      #3;
      chk("drive_b_before_reset", rd_enable, 32'h0000_0080);
      reset = 1'b1;
      #1;
      chk("async_reset_rd_enable", rd_enable, 32'd0);
      chk("async_reset_rsp_valid", 32'(rsp_valid), 32'd0);
      repeat (2) @(posedge clock);
      #2;
      reset = 1'b0;
      repeat (5) @(posedge clock);
      #2;
      send(5'd1, 5'd2, 32'h0000_0002, 32'h0000_0004, 32'h1111_1111, 32'h2222_2222, 2, 1'b0);
      req_valid = 1'b0;
      wait_done();

      // Equal operands: read once with dedup, twice without.
      send(5'd12, 5'd12, 32'h0000_1000, DEDUP ? 32'd0 : 32'h0000_1000,
           32'h1234_5678, 32'h1234_5678, DEDUP ? 1 : 2, 1'b0);
      req_valid = 1'b0;
      wait_done();

      // Continuous request/ready: one accept every four cycles.
      send(5'd7, 5'd3, 32'h0000_0080, 32'h0000_0008, 32'hDEAD_BEEF, 32'h0000_00AA, 2, 1'b0);
      send(5'd12, 5'd31, 32'h0000_1000, 32'h8000_0000, 32'h1234_5678, 32'hCAFE_F00D, 2, 1'b1);
      send(5'd2, 5'd1, 32'h0000_0004, 32'h0000_0002, 32'h2222_2222, 32'h1111_1111, 2, 1'b1);
      req_valid = 1'b0;
      wait_done();

      repeat (3) @(posedge clock);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // Hard stop so the bench never hangs.
   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
